// File: rtl/if_decode.sv
// Instruction fetch/decode front end: pulls a 32-bit instruction byte-by-byte
// from the shared memory port, decodes it and offers it to the instruction queue.
module if_decode #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        mem_gnt,
  output logic        mem_req,
  output logic [31:0] mem_a,
  input  logic [7:0]  mem_din,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        rob_full,
  output logic        have_input,
  output logic [31:0] instr_input,
  output logic [31:0] pc_out,
  output logic [16:0] opcode_if,
  output logic [4:0]  rd_if,
  output logic [4:0]  rs1_if,
  output logic [4:0]  rs2_if,
  output logic [31:0] imm_if
);

  typedef enum logic {FETCH, ISSUE} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [2:0]  req_cnt, rcv_cnt;
  logic        pend;
  logic [7:0]  b0, b1, b2;
  logic [31:0] word;
  logic [4:0]  rd_d, rs1_d, rs2_d;
  logic [31:0] imm_d;

  assign mem_a = pc + {29'b0, req_cnt};
  assign word  = {mem_din, b2, b1, b0};

  // Reset and flush suppress both the request and the issue in the same cycle.
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    have_input = 1'b0;
    if (rst_in || flush) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        FETCH: begin
          mem_req = rdy_in & mem_gnt & (req_cnt < 3'd4);
          if (pend && rcv_cnt == 3'd3) state_nxt = ISSUE;
        end
        ISSUE: begin
          have_input = rdy_in & ~rob_full;
          if (have_input) state_nxt = FETCH;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_comb begin
    rd_d  = word[11:7];
    rs1_d = word[19:15];
    rs2_d = 5'd0;
    imm_d = 32'd0;
    case (word[6:0])
      7'b0110011: rs2_d = word[24:20];
      7'b0000011, 7'b1100111: imm_d = {{20{word[31]}}, word[31:20]};
      7'b0010011: begin
        if (word[14:12] == 3'b001 || word[14:12] == 3'b101)
          imm_d = {27'd0, word[24:20]};
        else
          imm_d = {{20{word[31]}}, word[31:20]};
      end
      7'b0100011: begin
        rd_d  = 5'd0;
        rs2_d = word[24:20];
        imm_d = {{20{word[31]}}, word[31:25], word[11:7]};
      end
      7'b1100011: begin
        rd_d  = 5'd0;
        rs2_d = word[24:20];
        imm_d = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        rs1_d = 5'd0;
        imm_d = {word[31:12], 12'd0};
      end
      7'b1101111: begin
        rs1_d = 5'd0;
        imm_d = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
      end
      default: rs2_d = word[24:20];
    endcase
  end

  // Byte capture follows an outstanding request even while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      req_cnt     <= 3'd0;
      rcv_cnt     <= 3'd0;
      pend        <= 1'b0;
      b0          <= 8'd0;
      b1          <= 8'd0;
      b2          <= 8'd0;
      instr_input <= 32'd0;
      pc_out      <= 32'd0;
      opcode_if   <= 17'd0;
      rd_if       <= 5'd0;
      rs1_if      <= 5'd0;
      rs2_if      <= 5'd0;
      imm_if      <= 32'd0;
    end else if (flush) begin
      state   <= FETCH;
      pc      <= flush_pc;
      req_cnt <= 3'd0;
      rcv_cnt <= 3'd0;
      pend    <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= mem_req;
      if (mem_req) req_cnt <= req_cnt + 3'd1;
      if (pend) begin
        rcv_cnt <= rcv_cnt + 3'd1;
        case (rcv_cnt)
          3'd0: b0 <= mem_din;
          3'd1: b1 <= mem_din;
          3'd2: b2 <= mem_din;
          default: begin
            instr_input <= word;
            pc_out      <= pc;
            opcode_if   <= {word[31:25], word[14:12], word[6:0]};
            rd_if       <= rd_d;
            rs1_if      <= rs1_d;
            rs2_if      <= rs2_d;
            imm_if      <= imm_d;
          end
        endcase
      end
      if (have_input) begin
        pc      <= pc + 32'd4;
        req_cnt <= 3'd0;
        rcv_cnt <= 3'd0;
      end
    end
  end

endmodule

// File: doc/if_decode.md
Name: if_decode

Overview:
- Producer end of the instruction-queue input interface: fetches 32-bit instructions byte-by-byte from the shared byte-wide memory port.
- Assembles each instruction little-endian, decodes it into opcode, rd, rs1, rs2 and imm fields, and offers it on the queue's input handshake.
- Advances PC by 4 on each accepted issue; redirects to a new PC on flush.

Parameters:
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk_in  input  1  clock; all state updates on posedge.
- rst_in  input  1  synchronous reset, active-high.
- rdy_in  input  1  global ready; 0 freezes the block.
- mem_gnt  input  1  arbiter grants the byte port to this block this cycle.
- mem_req  output  1  byte read request this cycle.
- mem_a  output  32  byte address of the request.
- mem_din  input  8  read data for the request issued in the previous cycle.
- flush  input  1  redirect fetch.
- flush_pc  input  32  new PC, valid while flush=1.
- rob_full  input  1  queue cannot accept.
- have_input  output  1  instruction offered; transfer occurs on the same edge.
- instr_input  output  32  raw instruction.
- pc_out  output  32  PC of offered instruction.
- opcode_if  output  17  {instr[31:25], instr[14:12], instr[6:0]}.
- rd_if, rs1_if, rs2_if  output  5 each  register indices.
- imm_if  output  32  decoded immediate.

Behaviour:
- States: FETCH, ISSUE.
- Counters: req_cnt 0..4 (bytes requested), rcv_cnt 0..4 (bytes received). Flag pend (request outstanding).
- Reset:
  - pc=RESET_PC; state=FETCH; counters=0; pend=0.
  - All registered outputs 0; have_input=0; mem_req=0.
- FETCH requests:
  - mem_req = rdy_in & mem_gnt & (req_cnt<4), combinational.
  - mem_a = pc + req_cnt.
  - Each request increments req_cnt and sets pend for the next cycle.
- FETCH capture:
  - If pend, mem_din is written to byte[rcv_cnt] and rcv_cnt increments.
  - Capture is not gated by rdy_in or mem_gnt.
- mem_gnt=0: no request is made; captured bytes and counters are retained.
- Decode:
  - When the 4th byte is captured, the instruction is assembled as {b3,b2,b1,b0}.
  - Decoded fields are registered on that edge; state→ISSUE.
- Latency: with mem_gnt held high, requests go out in cycles 0–3, bytes return in cycles 1–4, and have_input rises in cycle 5. Minimum issue interval is 6 cycles.
- ISSUE:
  - have_input = rdy_in & ~rob_full & ~flush.
  - When have_input=1: pc<=pc+4 (mod 2^32), counters cleared, state→FETCH.
  - Otherwise all outputs are held stable. No fetch-ahead.
- Decode rules:
  - opcode_if is always the raw bit slice.
  - R (0110011): imm=0.
  - I (0000011, 1100111, and 0010011 except shifts): imm=sext(instr[31:20]).
  - Shifts (0010011 with funct3 001/101): imm=zext(instr[24:20]).
  - S (0100011): imm=sext{instr[31:25],instr[11:7]}; rd=0.
  - B (1100011): imm=sext{instr[31],instr[7],instr[30:25],instr[11:8],1'b0}; rd=0.
  - U (0110111, 0010111): imm={instr[31:12],12'b0}; rs1=0.
  - J (1101111): imm=sext{instr[31],instr[19:12],instr[20],instr[30:21],1'b0}; rs1=0.
  - rs2 is set only for R/S/B; otherwise 0.
  - Non-S/B rd = instr[11:7]; rs1 = instr[19:15] where applicable.
  - Unknown opcode: imm=0, rd/rs1/rs2 raw, still issued.
- Flush (priority below reset, above everything else):
  - pc<=flush_pc; state=FETCH; counters=0; pend=0 (next-cycle byte discarded).
  - have_input=0 and mem_req=0 in the flush cycle.
- rdy_in=0: no requests, no issue, pc/state/counters frozen except byte capture of an outstanding pend.
- Simultaneous flush and ISSUE acceptance: flush wins; no transfer.

Test Plan:
- Memory[0..3]=93 00 50 00, mem_gnt=1, rob_full=0, reset released → mem_a 0,1,2,3 in cycles 0–3. Cycle 5: have_input=1, instr_input=0x00500093, opcode_if=17'h00013, rd=1, rs1=0, rs2=0, imm=5, pc_out=0.
- Word 0x0020A423 at pc 4 → opcode_if=17'h00123, rd=0, rs1=1, rs2=2, imm=8, pc_out=4.
- Word 0xFE000EE3 (beq) → opcode_if=17'h1FC63, rs1=0, rs2=0, rd=0, imm=0xFFFFFFFC. Word 0x123450B7 → rd=1, rs1=0, imm=0x12345000.
- rob_full=1 for 3 cycles during ISSUE → have_input=0, outputs unchanged, no mem_req. Release → one transfer, next mem_a=pc+4.
- flush with flush_pc=0x100 after 2 bytes captured and 1 pending → pending byte ignored, next mem_a=0x100. First issued pc_out=0x100 with bytes from 0x100–0x103.
- mem_gnt alternating 1/0 → requests only on granted cycles, correct assembly, have_input after 4 granted cycles+2; rdy_in=0 in ISSUE → have_input=0, state held.
